// File: rtl/ask_frame_scheduler.sv
// Frame sequencer for the ASK transmitter: preamble, sync, length, payload from a byte FIFO, optional CRC-8 (ASK_FRAME_CRC_EN), guard.
// Frame starts one cycle after start is sampled; writes are accepted only while idle (wr_ready low when busy, full or start).
module ask_frame_scheduler #(
    parameter int         BASE_DIV      = 50000,
    parameter int         PREAMBLE_BITS = 16,
    parameter logic [7:0] SYNC_WORD     = 8'hD5,
    parameter int         FIFO_DEPTH    = 16,
    parameter int         GUARD_BITS    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [1:0]                    rate_sel,
    input  logic                          start,
    input  logic                          abort,
    output logic                          tx_bit,
    output logic                          tx_active,
    output logic                          bit_strobe,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int PW   = $clog2(BASE_DIV + 1);
    localparam int MAXP = (PREAMBLE_BITS > GUARD_BITS) ? PREAMBLE_BITS : GUARD_BITS;
    localparam int MAXB = (MAXP > 8) ? MAXP : 8;
    localparam int BW   = $clog2(MAXB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SYNC,
        S_LEN,
        S_PAYLOAD,
`ifdef ASK_FRAME_CRC_EN
        S_CRC,
`endif
        S_GUARD
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   cnt, cnt_n;
    logic [PW-1:0]   period, period_n;
    logic [BW-1:0]   bit_idx, bit_n;
    logic [7:0]      byte_idx, byte_n;
    logic [7:0]      len, len_n;
    logic [7:0]      sreg, sreg_n;
    logic            done_n, aborted_n;
    logic            pop, flush, wr_fire, bit_end;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full;

`ifdef ASK_FRAME_CRC_EN
    logic [7:0]      crc, crc_n;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction
`endif

    assign full       = (count == CW'(FIFO_DEPTH));
    assign fifo_count = count;
    assign busy       = (state != S_IDLE);
    assign tx_active  = busy;
    assign bit_strobe = busy && (cnt == '0);
    assign wr_ready   = !reset && (state == S_IDLE) && !full && !start;
    assign wr_fire    = wr_valid && wr_ready;
    assign bit_end    = (cnt == period - PW'(1));

    always_comb begin
        tx_bit = 1'b0;
        case (state)
            S_PREAMBLE: tx_bit = ~bit_idx[0];
            S_SYNC, S_LEN, S_PAYLOAD: tx_bit = sreg[7];
`ifdef ASK_FRAME_CRC_EN
            S_CRC:      tx_bit = sreg[7];
`endif
            default:    tx_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        period_n  = period;
        bit_n     = bit_idx;
        byte_n    = byte_idx;
        len_n     = len;
        sreg_n    = sreg;
        done_n    = 1'b0;
        aborted_n = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
`ifdef ASK_FRAME_CRC_EN
        crc_n     = crc;
`endif
        if (state != S_IDLE) begin
            cnt_n = bit_end ? '0 : cnt + PW'(1);
            // Each payload byte leaves the FIFO during its first strobe; sreg already holds it.
            pop   = (state == S_PAYLOAD) && (cnt == '0) && (bit_idx == '0);
        end
        case (state)
            S_IDLE: begin
                if (start && count != '0) begin
                    state_n  = S_PREAMBLE;
                    len_n    = 8'(count);
                    period_n = PW'(BASE_DIV) >> rate_sel;
                    cnt_n    = '0;
                    bit_n    = '0;
`ifdef ASK_FRAME_CRC_EN
                    crc_n    = crc8_step(8'h00, 8'(count));
`endif
                end
            end
            S_PREAMBLE: begin
                if (bit_end) begin
                    if (bit_idx == BW'(PREAMBLE_BITS - 1)) begin
                        state_n = S_SYNC;
                        bit_n   = '0;
                        sreg_n  = SYNC_WORD;
                    end else begin
                        bit_n   = bit_idx + BW'(1);
                    end
                end
            end
            S_SYNC: begin
                if (bit_end) begin
                    if (bit_idx == BW'(7)) begin
                        state_n = S_LEN;
                        bit_n   = '0;
                        sreg_n  = len;
                    end else begin
                        bit_n   = bit_idx + BW'(1);
                        sreg_n  = {sreg[6:0], 1'b0};
                    end
                end
            end
            S_LEN: begin
                if (bit_end) begin
                    if (bit_idx == BW'(7)) begin
                        state_n = S_PAYLOAD;
                        bit_n   = '0;
                        byte_n  = '0;
                        sreg_n  = mem[rd_ptr];
`ifdef ASK_FRAME_CRC_EN
                        crc_n   = crc8_step(crc, mem[rd_ptr]);
`endif
                    end else begin
                        bit_n   = bit_idx + BW'(1);
                        sreg_n  = {sreg[6:0], 1'b0};
                    end
                end
            end
            S_PAYLOAD: begin
                if (bit_end) begin
                    if (bit_idx != BW'(7)) begin
                        bit_n   = bit_idx + BW'(1);
                        sreg_n  = {sreg[6:0], 1'b0};
                    end else if (byte_idx == len - 8'd1) begin
                        bit_n   = '0;
`ifdef ASK_FRAME_CRC_EN
                        state_n = S_CRC;
                        sreg_n  = crc;
`else
                        state_n = S_GUARD;
`endif
                    end else begin
                        // rd_ptr already advanced by this byte's pop, so it addresses the next byte.
                        bit_n   = '0;
                        byte_n  = byte_idx + 8'd1;
                        sreg_n  = mem[rd_ptr];
`ifdef ASK_FRAME_CRC_EN
                        crc_n   = crc8_step(crc, mem[rd_ptr]);
`endif
                    end
                end
            end
`ifdef ASK_FRAME_CRC_EN
            S_CRC: begin
                if (bit_end) begin
                    if (bit_idx == BW'(7)) begin
                        state_n = S_GUARD;
                        bit_n   = '0;
                    end else begin
                        bit_n   = bit_idx + BW'(1);
                        sreg_n  = {sreg[6:0], 1'b0};
                    end
                end
            end
`endif
            S_GUARD: begin
                if (bit_end) begin
                    if (bit_idx == BW'(GUARD_BITS - 1)) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        bit_n   = bit_idx + BW'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_n   = S_IDLE;
            done_n    = 1'b0;
            aborted_n = 1'b1;
            flush     = 1'b1;
            pop       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            period   <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            len      <= '0;
            sreg     <= '0;
            done     <= 1'b0;
            aborted  <= 1'b0;
`ifdef ASK_FRAME_CRC_EN
            crc      <= '0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            period   <= period_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            len      <= len_n;
            sreg     <= sreg_n;
            done     <= done_n;
            aborted  <= aborted_n;
`ifdef ASK_FRAME_CRC_EN
            crc      <= crc_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Writes only happen in IDLE and pops only in PAYLOAD, so they never coincide.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (wr_fire) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count + CW'(1);
        end else if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            count  <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_ask_frame_scheduler.sv
// Randomized self-checking bench for ask_frame_scheduler; expected bit streams come from a frame-level model.
module tb_ask_frame_scheduler;

    localparam int BASE_DIV = 8;
    localparam int PRE      = 4;
    localparam int GUARD    = 2;
    localparam int DEPTH    = 16;
`ifdef ASK_FRAME_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, wr_valid, wr_ready, start, abort;
    logic [7:0] wr_data;
    logic [1:0] rate_sel;
    logic       tx_bit, tx_active, bit_strobe, busy, done, aborted;
    logic [4:0] fifo_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] pl_q[$];
    bit         exp_bits[$];
    bit         cap_bits[$];
    int  rf_done, rf_gap, rf_glitch, rf_inactive;
    bit  rf_act0, rf_busy0, rf_stb0, rf_end_active, rf_done2;

    always #5 clk = ~clk;

    ask_frame_scheduler #(
        .BASE_DIV(BASE_DIV), .PREAMBLE_BITS(PRE), .SYNC_WORD(8'hD5),
        .FIFO_DEPTH(DEPTH), .GUARD_BITS(GUARD)
    ) dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .rate_sel(rate_sel), .start(start), .abort(abort),
        .tx_bit(tx_bit), .tx_active(tx_active), .bit_strobe(bit_strobe),
        .busy(busy), .done(done), .aborted(aborted), .fifo_count(fifo_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fifo();
        foreach (pl_q[i]) begin
            wr_data  = pl_q[i];
            wr_valid = 1'b1;
            step();
            wr_valid = 1'b0;
        end
    endtask

    // Reference frame: alternating preamble, sync, length, payload, optional CRC-8 (bit-serial division), guard zeros.
    function automatic void build_expected();
        logic [7:0] msg[$];
        logic [7:0] sw;
        logic [7:0] crc;
        bit         fb;
        sw = 8'hD5;
        exp_bits.delete();
        for (int i = 0; i < PRE; i++) exp_bits.push_back((i % 2) == 0);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(sw[i]);
        msg.push_back(8'(pl_q.size()));
        foreach (pl_q[k]) msg.push_back(pl_q[k]);
        crc = 8'h00;
        foreach (msg[k]) begin
            for (int i = 7; i >= 0; i--) begin
                exp_bits.push_back(msg[k][i]);
                fb  = crc[7] ^ msg[k][i];
                crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        if (CRC_ON) for (int i = 7; i >= 0; i--) exp_bits.push_back(crc[i]);
        for (int i = 0; i < GUARD; i++) exp_bits.push_back(1'b0);
    endfunction

    // Starts a frame and records what the DUT emits; cycle 0 is the cycle after start is sampled.
    task automatic run_frame(input int rate, input int new_rate);
        int last;
        bit prev;
        rate_sel = 2'(rate);
        start = 1'b1;
        step();
        start = 1'b0;
        rf_act0 = tx_active; rf_busy0 = busy; rf_stb0 = bit_strobe;
        cap_bits.delete();
        rf_gap = 0; rf_glitch = 0; rf_inactive = 0; rf_done = -1;
        rf_end_active = 1'b1; rf_done2 = 1'b1;
        last = -1;
        prev = tx_bit;
        for (int c = 0; c < 6000; c++) begin
            if (c == 5) rate_sel = 2'(new_rate);
            if (done) begin
                rf_done = c;
                rf_end_active = tx_active;
                break;
            end
            if (!tx_active) rf_inactive++;
            if (bit_strobe) begin
                cap_bits.push_back(tx_bit);
                if (last >= 0 && (c - last) != (BASE_DIV >> rate)) rf_gap++;
                last = c;
            end else if (tx_bit !== prev) begin
                rf_glitch++;
            end
            prev = tx_bit;
            step();
        end
        if (rf_done >= 0) begin
            step();
            rf_done2 = done;
        end
    endtask

    // Runs one frame on bytes already loaded from pl_q and compares it with the model.
    task automatic test_frame(input string name, input int rate, input int new_rate);
        int nbad;
        int exp_done;
        build_expected();
        exp_done = (BASE_DIV >> rate) * exp_bits.size();
        run_frame(rate, new_rate);
        checks++;
        if ({rf_act0, rf_busy0, rf_stb0} !== 3'b111) begin
            errors++;
            $display("FAIL %s first_cycle act/busy/strobe got=%b exp=111", name, {rf_act0, rf_busy0, rf_stb0});
        end
        checks++;
        if (cap_bits.size() != exp_bits.size()) begin
            errors++;
            $display("FAIL %s bit_count got=%0d exp=%0d", name, cap_bits.size(), exp_bits.size());
        end
        nbad = 0;
        for (int i = 0; i < cap_bits.size() && i < exp_bits.size(); i++)
            if (cap_bits[i] !== exp_bits[i]) nbad++;
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL %s bit_values wrong=%0d exp=0", name, nbad);
        end
        checks++;
        if (rf_gap != 0 || rf_glitch != 0) begin
            errors++;
            $display("FAIL %s strobe_timing gaps=%0d glitches=%0d exp=0/0", name, rf_gap, rf_glitch);
        end
        checks++;
        if (rf_done != exp_done) begin
            errors++;
            $display("FAIL %s done_cycle got=%0d exp=%0d", name, rf_done, exp_done);
        end
        checks++;
        if (rf_inactive != 0 || rf_end_active !== 1'b0 || rf_done2 !== 1'b0) begin
            errors++;
            $display("FAIL %s active_window inactive=%0d end_active=%b done_next=%b exp=0/0/0",
                     name, rf_inactive, rf_end_active, rf_done2);
        end
        checks++;
        if (fifo_count !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_frame fifo_count=%0d busy=%b exp=0/0", name, fifo_count, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({tx_bit, tx_active, bit_strobe, busy, done, aborted, wr_ready} !== 7'b0 || fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b cnt=%0d exp=0000000 cnt=0",
                     {tx_bit, tx_active, bit_strobe, busy, done, aborted, wr_ready}, fifo_count);
        end
        reset = 1'b0;
        step();
        checks++;
        if (wr_ready !== 1'b1 || fifo_count !== 5'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release wr_ready=%b cnt=%0d busy=%b exp=1/0/0", wr_ready, fifo_count, busy);
        end
    endtask

    task automatic test_basic();
        pl_q = '{8'hA5, 8'h3C};
        load_fifo();
        checks++;
        if (fifo_count !== 5'd2) begin
            errors++;
            $display("FAIL basic_count got=%0d exp=2", fifo_count);
        end
        test_frame("basic", 0, 0);
    endtask

    task automatic test_rate_change();
        pl_q = '{8'h01};
        load_fifo();
        test_frame("rate2_midchange", 2, 0);
    endtask

    task automatic test_empty_start();
        int stb;
        stb = 0;
        start = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_blocks_write wr_ready=%b exp=0", wr_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (busy || bit_strobe || tx_active) stb++;
        end
        start = 1'b0;
        step();
        checks++;
        if (stb != 0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_start active_cycles=%0d wr_ready=%b exp=0/1", stb, wr_ready);
        end
    endtask

    task automatic test_fill();
        pl_q.delete();
        for (int i = 0; i < DEPTH; i++) pl_q.push_back(8'($urandom_range(0, 255)));
        load_fifo();
        checks++;
        if (fifo_count !== 5'd16 || wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full cnt=%0d wr_ready=%b exp=16/0", fifo_count, wr_ready);
        end
        wr_data = 8'hEE;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        checks++;
        if (fifo_count !== 5'd16) begin
            errors++;
            $display("FAIL fill_overflow cnt=%0d exp=16", fifo_count);
        end
        test_frame("full16", 0, 0);
    endtask

    task automatic test_abort_idle();
        pl_q = '{8'($urandom_range(0, 255))};
        load_fifo();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (fifo_count !== 5'd1 || aborted !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle cnt=%0d aborted=%b busy=%b exp=1/0/0", fifo_count, aborted, busy);
        end
        test_frame("after_idle_abort", 1, 1);
    endtask

    task automatic test_abort_payload();
        int dones;
        pl_q.delete();
        for (int i = 0; i < 4; i++) pl_q.push_back(8'($urandom_range(0, 255)));
        load_fifo();
        rate_sel = 2'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        // Second payload byte spans cycles 224..287 at 8 cycles per bit.
        dones = 0;
        for (int c = 0; c < 230; c++) begin
            if (done) dones++;
            step();
        end
        checks++;
        if (fifo_count !== 5'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre cnt=%0d busy=%b exp=2/1", fifo_count, busy);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({tx_active, tx_bit, busy, done, aborted} !== 5'b00001 || fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL abort_effect act/bit/busy/done/aborted=%b cnt=%0d exp=00001 cnt=0",
                     {tx_active, tx_bit, busy, done, aborted}, fifo_count);
        end
        step();
        for (int c = 0; c < 20; c++) begin
            if (done || aborted) dones++;
            step();
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_after stray_done_or_aborted=%0d exp=0", dones);
        end
    endtask

    task automatic test_random_frames();
        int n, r;
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, DEPTH);
            r = $urandom_range(0, 2);
            pl_q.delete();
            for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
            load_fifo();
            test_frame($sformatf("random%0d_len%0d_rate%0d", k, n, r), r, $urandom_range(0, 2));
        end
    endtask

    initial begin
        reset = 1'b1; wr_data = 8'h00; wr_valid = 1'b0;
        rate_sel = 2'd0; start = 1'b0; abort = 1'b0;
        test_reset();
        test_basic();
        test_rate_change();
        test_empty_start();
        test_fill();
        test_abort_idle();
        test_abort_payload();
        test_random_frames();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
